// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM with a
// stability counter, and a long-press detector. All outputs are registered
// and the press/release/long indications are single-cycle pulses.
module button_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int LONG_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES) + 1;
  localparam int LONG_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST   = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT    = LONG_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LONG_W-1:0] r_long_cnt;
  logic              r_long_done;

  state_t            w_state_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic              w_level_n;
  logic              w_press_n;
  logic              w_release_n;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic: a sample disagreeing with the level advances the
  // window, an agreeing sample collapses back and restarts it.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_level_n   = btn_level;
    w_press_n   = 1'b0;
    w_release_n = 1'b0;
    case (r_state)
      IDLE, PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_n = PRESSED;
          w_cnt_n   = '0;
          w_level_n = 1'b1;
          w_press_n = 1'b1;
        end else begin
          w_state_n = PRESS_WAIT;
          w_cnt_n   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        if (r_sync2) begin
          w_state_n = PRESSED;
          w_cnt_n   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_n   = IDLE;
          w_cnt_n     = '0;
          w_level_n   = 1'b0;
          w_release_n = 1'b1;
        end else begin
          w_state_n = RELEASE_WAIT;
          w_cnt_n   = r_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Debounce state, counter and registered level/edge outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      btn_level   <= w_level_n;
      btn_press   <= w_press_n;
      btn_release <= w_release_n;
    end
  end

  // Long-press timer: restarts on each press, fires once, and a release
  // landing on the firing edge takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_long_cnt  <= '0;
      r_long_done <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (w_press_n) begin
        r_long_cnt  <= '0;
        r_long_done <= 1'b0;
      end else if (w_release_n) begin
        r_long_done <= 1'b0;
      end else if (btn_level && !r_long_done) begin
        if (r_long_cnt == LONG_LAST) begin
          r_long_cnt  <= LONG_SAT;
          r_long_done <= 1'b1;
          btn_long    <= 1'b1;
        end else begin
          r_long_cnt <= r_long_cnt + LONG_W'(1);
        end
      end
    end
  end

endmodule
